// File: rtl/acc32_stage.sv
`default_nettype none
// ============================================================================
//  Module   : acc32_stage
//  Brief    : Valid/ready accumulator stage around a ripple-carry adder with
//             carry/overflow flags and a wrapping op counter.
//             Define ACC_SATURATE_EN to clamp acc on signed overflow.
//  Revision : 1.0  initial release
// ============================================================================
module acc32_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic             ovf,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] C_OP_ADD   = 2'b00;
    localparam logic [1:0] C_OP_SUB   = 2'b01;
    localparam logic [1:0] C_OP_LOAD  = 2'b10;
    localparam logic [1:0] C_OP_CLEAR = 2'b11;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t           r_state_q;
    state_t           r_state_d;
    logic [WIDTH-1:0] r_acc_q;
    logic [WIDTH-1:0] r_acc_d;
    logic             r_carry_q;
    logic             r_carry_d;
    logic             r_ovf_q;
    logic             r_ovf_d;
    logic             r_sticky_q;
    logic             r_sticky_d;
    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] r_cnt_d;

    logic             w_accept;
    logic             w_is_sub;
    logic [WIDTH-1:0] w_add_a;
    logic [WIDTH-1:0] w_add_b;
    logic [WIDTH-1:0] w_add_s;
    logic [WIDTH:0]   w_chain;
    logic             w_add_cout;
    logic             w_add_ovf;
    logic [WIDTH-1:0] w_arith_res;

    // A held result blocks new input unless downstream drains it this cycle.
    assign in_ready = (r_state_q == S_IDLE) || out_ready;
    assign w_accept = in_valid && in_ready;

    assign w_is_sub   = (in_op == C_OP_SUB);
    assign w_add_a    = r_acc_q;
    assign w_add_b    = w_is_sub ? ~in_data : in_data;
    assign w_chain[0] = w_is_sub;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ripple
            assign w_add_s[gi]     = w_add_a[gi] ^ w_add_b[gi] ^ w_chain[gi];
            assign w_chain[gi + 1] = (w_add_a[gi] & w_add_b[gi])
                                   | (w_chain[gi] & (w_add_a[gi] ^ w_add_b[gi]));
        end
    endgenerate

    assign w_add_cout = w_chain[WIDTH];
    assign w_add_ovf  = (w_add_a[WIDTH-1] == w_add_b[WIDTH-1])
                      && (w_add_s[WIDTH-1] != w_add_a[WIDTH-1]);

`ifdef ACC_SATURATE_EN
    localparam logic [WIDTH-1:0] C_SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] C_SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // The sign of the accumulator tells which rail the true result passed.
    assign w_arith_res = !w_add_ovf        ? w_add_s   :
                         w_add_a[WIDTH-1]  ? C_SAT_MIN : C_SAT_MAX;
`else
    assign w_arith_res = w_add_s;
`endif

    always_comb begin
        r_state_d  = r_state_q;
        r_acc_d    = r_acc_q;
        r_carry_d  = r_carry_q;
        r_ovf_d    = r_ovf_q;
        r_sticky_d = r_sticky_q;
        r_cnt_d    = r_cnt_q;

        if (w_accept) begin
            r_state_d = S_RESP;
            r_cnt_d   = r_cnt_q + CNT_W'(1);
            case (in_op)
                C_OP_ADD, C_OP_SUB: begin
                    r_acc_d    = w_arith_res;
                    r_carry_d  = w_add_cout;
                    r_ovf_d    = w_add_ovf;
                    r_sticky_d = r_sticky_q | w_add_ovf;
                end
                C_OP_LOAD: begin
                    r_acc_d   = in_data;
                    r_carry_d = 1'b0;
                    r_ovf_d   = 1'b0;
                end
                C_OP_CLEAR: begin
                    r_acc_d    = '0;
                    r_carry_d  = 1'b0;
                    r_ovf_d    = 1'b0;
                    r_sticky_d = 1'b0;
                end
                default: begin
                    r_acc_d = r_acc_q;
                end
            endcase
        end else if ((r_state_q == S_RESP) && out_ready) begin
            r_state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= S_IDLE;
            r_acc_q    <= '0;
            r_carry_q  <= 1'b0;
            r_ovf_q    <= 1'b0;
            r_sticky_q <= 1'b0;
            r_cnt_q    <= '0;
        end else begin
            r_state_q  <= r_state_d;
            r_acc_q    <= r_acc_d;
            r_carry_q  <= r_carry_d;
            r_ovf_q    <= r_ovf_d;
            r_sticky_q <= r_sticky_d;
            r_cnt_q    <= r_cnt_d;
        end
    end

    assign out_valid  = (r_state_q == S_RESP);
    assign acc        = r_acc_q;
    assign carry      = r_carry_q;
    assign ovf        = r_ovf_q;
    assign ovf_sticky = r_sticky_q;
    assign op_count   = r_cnt_q;

endmodule
`default_nettype wire
